// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    HALTED
  } state_t;

  localparam int          INSTR_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_wait_timer.sv
// Fetch watchdog counter: cleared on grant, counts while enabled,
// flags expiry on the LIMIT-th enabled cycle.
module pc_wait_timer #(
  parameter int LIMIT = 255,
  parameter int WIDTH = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  // The cycle that sees LAST is the LIMIT-th cycle spent waiting.
  assign expired = (count == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned redirect targets trap and halt.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC      = DEFAULT_RESET_VEC,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemGnt,
  input  logic        imemRspValid,
  input  logic [31:0] imemRspData,
  output logic [31:0] instr,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  input  logic        haltReq,
  output logic        halted,
  output logic        fetchTimeout,
`ifdef PC_MISALIGN_TRAP_EN
  output logic        misalignTrap,
`endif
  output state_t      state
);

  state_t      cur_state, nxt_state;
  logic [31:0] pc_d, instr_d, tgt, tgt_d, load_tgt;
  logic        timeout_d, pend_redirect, pend_d, squash, squash_d;
  logic        tmr_clear, tmr_en, tmr_expired, load_req;
`ifdef PC_MISALIGN_TRAP_EN
  logic        trap_d;
`endif

  pc_wait_timer #(
    .LIMIT(TIMEOUT_CYCLES),
    .WIDTH($clog2(TIMEOUT_CYCLES + 1))
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  assign pcPlus4    = pc + 32'(INSTR_BYTES);
  assign imemReq    = (cur_state == REQ);
  assign imemAddr   = pc;
  assign instrValid = (cur_state == HOLD);
  assign halted     = (cur_state == HALTED);
  assign state      = cur_state;

  always_comb begin
    nxt_state = cur_state;
    pc_d      = pc;
    instr_d   = instr;
    timeout_d = fetchTimeout;
    pend_d    = pend_redirect;
    squash_d  = squash;
    tgt_d     = tgt;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    load_req  = 1'b0;
    load_tgt  = tgt;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d    = misalignTrap;
`endif
    case (cur_state)
      IDLE: nxt_state = haltReq ? HALTED : REQ;
      REQ: begin
        if (redirectValid) begin
          pend_d = 1'b1;
          tgt_d  = redirectTarget;
        end
        if (imemGnt) begin
          nxt_state = WAIT;
          tmr_clear = 1'b1;
        end
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (redirectValid) begin
          squash_d = 1'b1;
          tgt_d    = redirectTarget;
        end
        if (imemRspValid) begin
          // A redirect arriving with the response still kills it, newest target wins.
          if (squash || pend_redirect || redirectValid) begin
            load_req  = 1'b1;
            load_tgt  = redirectValid ? redirectTarget : tgt;
            pend_d    = 1'b0;
            squash_d  = 1'b0;
            nxt_state = REQ;
          end else begin
            instr_d   = imemRspData;
            nxt_state = HOLD;
          end
        end else if (tmr_expired) begin
          timeout_d = 1'b1;
          nxt_state = HALTED;
        end
      end
      HOLD: begin
        if (redirectValid) begin
          load_req  = 1'b1;
          load_tgt  = redirectTarget;
          nxt_state = REQ;
        end else if (instrReady) begin
          pc_d      = pcPlus4;
          nxt_state = haltReq ? HALTED : REQ;
        end
      end
      default: nxt_state = cur_state;
    endcase

    if (load_req) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (load_tgt[1:0] != 2'b00) begin
        trap_d    = 1'b1;
        nxt_state = HALTED;
      end else begin
        pc_d = load_tgt;
      end
`else
      pc_d = load_tgt & ~32'h3;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state     <= IDLE;
      pc            <= RESET_VEC;
      instr         <= '0;
      fetchTimeout  <= 1'b0;
      pend_redirect <= 1'b0;
      squash        <= 1'b0;
      tgt           <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      misalignTrap  <= 1'b0;
`endif
    end else begin
      cur_state     <= nxt_state;
      pc            <= pc_d;
      instr         <= instr_d;
      fetchTimeout  <= timeout_d;
      pend_redirect <= pend_d;
      squash        <= squash_d;
      tgt           <= tgt_d;
`ifdef PC_MISALIGN_TRAP_EN
      misalignTrap  <= trap_d;
`endif
    end
  end

endmodule
